// File: rtl/multi_channel_fifo_sdram_arbiter.sv
`default_nettype none
// ============================================================================
// multi_channel_fifo_sdram_arbiter
// Round-robin arbiter that serialises NUM_CH command FIFOs onto one SDRAM port.
// Optional SDRAM watchdog: define ARB_SDRAM_TIMEOUT_EN.
// Revision: 1.0
// ============================================================================
module multi_channel_fifo_sdram_arbiter #(
  parameter int NUM_CH      = 4,
  parameter int FIFO_LAT    = 1,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                      clk2M,
  input  logic                      reset,
  input  logic                      sdramReady,
  input  logic [NUM_CH-1:0]         fifoDataEmpty,
  input  logic [NUM_CH-1:0]         fifoDataFull,
  input  logic [NUM_CH-1:0]         writeSDRAM,
  output logic [NUM_CH-1:0]         fifoReadStrobe,
  output logic [NUM_CH-1:0]         fifoWriteStrobe,
  output logic                      sdramReq,
  output logic                      sdramWE,
  input  logic                      sdramDone,
  output logic [$clog2(NUM_CH)-1:0] grantCh,
  output logic                      arbBusy,
  output logic                      simpleArbiterError
);
  localparam int CW = $clog2(NUM_CH);
  localparam int LW = 2;

  typedef enum logic [2:0] {
    WAIT_INIT  = 3'd0,
    IDLE       = 3'd1,
    FIFO_WAIT  = 3'd2,
    ISSUE      = 3'd3,
    SDRAM_WAIT = 3'd4,
    RESPOND    = 3'd5
  } state_t;

  state_t            state;
  state_t            stateNext;
  logic [CW-1:0]     lastGrant;
  logic [CW-1:0]     pickCh;
  logic              pickValid;
  logic [NUM_CH-1:0] eligible;
  logic [LW-1:0]     latCnt;
  logic              wdExpired;
  logic              timeoutHit;
  logic              badState;
  logic              loadGrant;
  logic              loadWE;
  logic              clearWE;

  assign eligible = ~fifoDataEmpty & ~fifoDataFull;
  assign arbBusy  = (state != IDLE) && (state != WAIT_INIT);

  // Search starts one past the last winner so every channel gets a turn.
  always_comb begin
    int idx;
    idx       = 0;
    pickValid = 1'b0;
    pickCh    = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      idx = int'(lastGrant) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!pickValid && eligible[CW'(idx)]) begin
        pickValid = 1'b1;
        pickCh    = CW'(idx);
      end
    end
  end

`ifdef ARB_SDRAM_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYC + 1);
  logic [WW-1:0] wdCnt;

  always_ff @(posedge clk2M) begin
    if (reset || state != SDRAM_WAIT) wdCnt <= '0;
    else                              wdCnt <= wdCnt + 1'b1;
  end

  assign wdExpired = (state == SDRAM_WAIT) && (wdCnt == WW'(TIMEOUT_CYC - 1));
`else
  assign wdExpired = 1'b0;
`endif

  always_ff @(posedge clk2M) begin
    if (reset) state <= WAIT_INIT;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext       = state;
    fifoReadStrobe  = '0;
    fifoWriteStrobe = '0;
    sdramReq        = 1'b0;
    loadGrant       = 1'b0;
    loadWE          = 1'b0;
    clearWE         = 1'b0;
    timeoutHit      = 1'b0;
    badState        = 1'b0;
    case (state)
      WAIT_INIT: if (sdramReady) stateNext = IDLE;
      IDLE: begin
        if (!sdramReady) begin
          stateNext = WAIT_INIT;
        end else if (pickValid) begin
          fifoReadStrobe[pickCh] = 1'b1;
          loadGrant              = 1'b1;
          stateNext              = FIFO_WAIT;
        end
      end
      FIFO_WAIT: begin
        if (latCnt == LW'(FIFO_LAT - 1)) begin
          loadWE    = 1'b1;
          stateNext = ISSUE;
        end
      end
      ISSUE: begin
        sdramReq  = 1'b1;
        stateNext = SDRAM_WAIT;
      end
      SDRAM_WAIT: begin
        if (sdramDone) begin
          clearWE   = 1'b1;
          stateNext = sdramWE ? IDLE : RESPOND;
        end else if (wdExpired) begin
          clearWE    = 1'b1;
          timeoutHit = 1'b1;
          stateNext  = IDLE;
        end
      end
      RESPOND: begin
        fifoWriteStrobe[grantCh] = 1'b1;
        stateNext                = IDLE;
      end
      default: begin
        badState  = 1'b1;
        clearWE   = 1'b1;
        stateNext = WAIT_INIT;
      end
    endcase
    // Strobes are combinational, so suppress them while reset is held.
    if (reset) begin
      fifoReadStrobe  = '0;
      fifoWriteStrobe = '0;
      sdramReq        = 1'b0;
    end
  end

  always_ff @(posedge clk2M) begin
    if (reset) begin
      lastGrant          <= CW'(NUM_CH - 1);
      grantCh            <= '0;
      sdramWE            <= 1'b0;
      latCnt             <= '0;
      simpleArbiterError <= 1'b0;
    end else begin
      if (loadGrant) begin
        lastGrant <= pickCh;
        grantCh   <= pickCh;
      end
      if (state == FIFO_WAIT) latCnt <= latCnt + 1'b1;
      else                    latCnt <= '0;
      if (loadWE)       sdramWE <= writeSDRAM[grantCh];
      else if (clearWE) sdramWE <= 1'b0;
      if (badState || timeoutHit) simpleArbiterError <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multi_channel_fifo_sdram_arbiter.sv
`default_nettype none
// Scoreboard bench for multi_channel_fifo_sdram_arbiter: directed commands,
// expected strobe/request events queued and checked by an independent monitor.
module tb_multi_channel_fifo_sdram_arbiter;
  localparam int NCH = 4;
  localparam int LAT = 1;

  localparam int EV_RD  = 0;
  localparam int EV_REQ = 1;
  localparam int EV_WR  = 2;

  logic           clk2M;
  logic           reset;
  logic           sdramReady;
  logic [NCH-1:0] fifoDataEmpty;
  logic [NCH-1:0] fifoDataFull;
  logic [NCH-1:0] writeSDRAM;
  logic [NCH-1:0] fifoReadStrobe;
  logic [NCH-1:0] fifoWriteStrobe;
  logic           sdramReq;
  logic           sdramWE;
  logic           sdramDone;
  logic [1:0]     grantCh;
  logic           arbBusy;
  logic           simpleArbiterError;

  typedef struct {
    int kind;
    int val;
    int cyc;
  } ev_t;

  ev_t expQ[$];
  int  tests = 0;
  int  failed = 0;
  int  cyc = 0;
  int  pushed[NCH] = '{default: 0};
  int  popped[NCH] = '{default: 0};
  int  lastRdCyc = -100;
  int  lastReqCyc = -100;
  int  lastDoneCyc = -100;
  int  respOn;
  int  doneDelay;

  multi_channel_fifo_sdram_arbiter #(
    .NUM_CH(NCH), .FIFO_LAT(LAT), .TIMEOUT_CYC(64)
  ) dut (
    .clk2M(clk2M), .reset(reset), .sdramReady(sdramReady),
    .fifoDataEmpty(fifoDataEmpty), .fifoDataFull(fifoDataFull),
    .writeSDRAM(writeSDRAM), .fifoReadStrobe(fifoReadStrobe),
    .fifoWriteStrobe(fifoWriteStrobe), .sdramReq(sdramReq),
    .sdramWE(sdramWE), .sdramDone(sdramDone), .grantCh(grantCh),
    .arbBusy(arbBusy), .simpleArbiterError(simpleArbiterError)
  );

  initial clk2M = 1'b0;
  always #5 clk2M = ~clk2M;

  always @(posedge clk2M) cyc <= cyc + 1;

  // Command FIFO model: a channel is non-empty while pushes exceed pops.
  always_comb begin
    fifoDataEmpty = '1;
    for (int c = 0; c < NCH; c++) fifoDataEmpty[c] = (pushed[c] == popped[c]);
  end

  always @(posedge clk2M) begin
    for (int c = 0; c < NCH; c++)
      if (fifoReadStrobe[c]) popped[c] <= popped[c] + 1;
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic pushEv(input int kind, input int val, input int c);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    e.cyc  = c;
    expQ.push_back(e);
  endtask

  task automatic popCheck(input string name, input int kind, input int val);
    ev_t e;
    if (expQ.size() == 0) begin
      tests++;
      failed++;
      $display("FAIL unexpected_%s: got %0d expected no event (cycle %0d)", name, val, cyc);
    end else begin
      e = expQ.pop_front();
      check({name, "_kind"}, kind, e.kind);
      check({name, "_val"}, val, e.val);
      if (e.cyc != 0) check({name, "_cyc"}, cyc, e.cyc);
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk2M) begin
    if (sdramDone) lastDoneCyc = cyc;
    if (fifoReadStrobe != '0) begin
      check("rd_onehot", $countones(fifoReadStrobe), 1);
      popCheck("rdstrobe", EV_RD, int'(fifoReadStrobe));
      lastRdCyc = cyc;
    end
    if (sdramReq) begin
      check("req_latency", cyc - lastRdCyc, LAT + 1);
      popCheck("sdramreq", EV_REQ, int'({grantCh, sdramWE}));
      lastReqCyc = cyc;
    end
    if (fifoWriteStrobe != '0) begin
      check("wr_onehot", $countones(fifoWriteStrobe), 1);
      check("wr_latency", cyc - lastDoneCyc, 1);
      popCheck("wrstrobe", EV_WR, int'(fifoWriteStrobe));
    end
  end

  // SDRAM controller model: completes doneDelay cycles after each request.
  initial begin
    sdramDone = 1'b0;
    forever begin
      @(negedge clk2M);
      if (sdramReq && respOn != 0) begin
        repeat (doneDelay) @(posedge clk2M);
        #1 sdramDone = 1'b1;
        @(posedge clk2M);
        #1 sdramDone = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk2M);
      #1;
    end
  endtask

  task automatic waitUntil(input int target);
    int guard = 0;
    while (cyc < target && guard < 1000) begin
      step(1);
      guard++;
    end
  endtask

  task automatic drain(input string name, input int maxCyc);
    int n = 0;
    while (expQ.size() != 0 && n < maxCyc) begin
      step(1);
      n++;
    end
    check({name, "_drain"}, expQ.size(), 0);
    expQ.delete();
  endtask

  task automatic doReset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
  endtask

  int t0;
  int r;

  initial begin
    reset      = 1'b1;
    sdramReady = 1'b0;
    fifoDataFull = '0;
    writeSDRAM = 4'b1111;
    respOn     = 1;
    doneDelay  = 2;
    step(3);
    reset = 1'b0;

    check("rst_busy", int'(arbBusy), 0);
    check("rst_grant", int'(grantCh), 0);
    check("rst_err", int'(simpleArbiterError), 0);
    check("rst_we", int'(sdramWE), 0);

    // Held in WAIT_INIT while the SDRAM is not ready, despite a pending write.
    pushed[0]++;
    step(10);
    check("init_busy", int'(arbBusy), 0);
    sdramReady = 1'b1;
    t0 = cyc;
    pushEv(EV_RD, 4'b0001, t0 + 1);
    pushEv(EV_REQ, 0 * 2 + 1, t0 + 3);
    drain("init", 20);
    step(8);

    // Single read on channel 2, completion 5 cycles after request.
    writeSDRAM[2] = 1'b0;
    doneDelay = 5;
    t0 = cyc;
    pushed[2]++;
    pushEv(EV_RD, 4'b0100, t0);
    pushEv(EV_REQ, 2 * 2 + 0, t0 + 2);
    pushEv(EV_WR, 4'b0100, t0 + 8);
    drain("read2", 30);
    step(5);
    check("read2_idle", int'(arbBusy), 0);

    // Fresh reset: all channels loaded with writes, strict round-robin order.
    doReset();
    writeSDRAM = 4'b1111;
    doneDelay = 1;
    for (int c = 0; c < NCH; c++) pushed[c] += 2;
    for (int k = 0; k < 2; k++)
      for (int c = 0; c < NCH; c++) begin
        pushEv(EV_RD, 1 << c, 0);
        pushEv(EV_REQ, c * 2 + 1, 0);
      end
    drain("rrobin", 100);
    step(5);

    // Channel 1 blocked by a full response FIFO; channel 3 read goes first.
    fifoDataFull[1] = 1'b1;
    writeSDRAM[3] = 1'b0;
    doneDelay = 2;
    pushed[1]++;
    pushed[3]++;
    pushEv(EV_RD, 4'b1000, 0);
    pushEv(EV_REQ, 3 * 2 + 0, 0);
    pushEv(EV_WR, 4'b1000, 0);
    drain("fullskip", 30);
    step(8);
    check("fullskip_pending", int'(fifoDataEmpty[1]), 0);
    pushEv(EV_RD, 4'b0010, 0);
    pushEv(EV_REQ, 1 * 2 + 1, 0);
    fifoDataFull[1] = 1'b0;
    drain("fullclear", 30);
    step(5);

    // Withheld completion on a channel 0 read.
    respOn = 0;
    writeSDRAM[0] = 1'b0;
    pushed[0]++;
    pushEv(EV_RD, 4'b0001, 0);
    pushEv(EV_REQ, 0 * 2 + 0, 0);
    drain("tmo", 20);
    r = lastReqCyc;
`ifdef ARB_SDRAM_TIMEOUT_EN
    waitUntil(r + 64);
    check("tmo_err_before", int'(simpleArbiterError), 0);
    check("tmo_busy_before", int'(arbBusy), 1);
    step(1);
    check("tmo_err_after", int'(simpleArbiterError), 1);
    check("tmo_idle_after", int'(arbBusy), 0);
    check("tmo_we_after", int'(sdramWE), 0);
    step(10);
    check("tmo_err_sticky", int'(simpleArbiterError), 1);
`else
    waitUntil(r + 100);
    check("nowd_busy", int'(arbBusy), 1);
    check("nowd_err", int'(simpleArbiterError), 0);
`endif

    // Reset in SDRAM_WAIT followed by a late completion pulse.
    doReset();
    check("rst2_err", int'(simpleArbiterError), 0);
    respOn = 1;
    doneDelay = 8;
    pushed[0]++;
    pushEv(EV_RD, 4'b0001, 0);
    pushEv(EV_REQ, 0 * 2 + 0, 0);
    drain("midrst", 20);
    r = lastReqCyc;
    waitUntil(r + 2);
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    check("midrst_busy", int'(arbBusy), 0);
    check("midrst_we", int'(sdramWE), 0);
    check("midrst_grant", int'(grantCh), 0);
    step(12);
    check("late_done_busy", int'(arbBusy), 0);
    check("late_done_err", int'(simpleArbiterError), 0);
    check("late_done_queue", expQ.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multi_channel_fifo_sdram_arbiter.md
MULTI_CHANNEL_FIFO_SDRAM_ARBITER -- requirements
Module: multi_channel_fifo_sdram_arbiter

Interface
REQ-001 The block SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-002 Parameter NUM_CH, default 4, SHALL set the number of serial-protocol FIFO channels (legal range 2..8).
REQ-003 Parameter FIFO_LAT, default 1, SHALL set the cycles from fifoReadStrobe to valid writeSDRAM (legal range 1..3).
REQ-004 Parameter TIMEOUT_CYC, default 64, SHALL set the SDRAM completion watchdog limit in cycles.
REQ-005 Port clk2M  in  1  SHALL be the single system clock.
REQ-006 Port reset  in  1  SHALL be the synchronous active-high reset.
REQ-007 Port sdramReady  in  1  SHALL indicate the SDRAM controller is initialised.
REQ-008 Port fifoDataEmpty  in  NUM_CH  SHALL flag, per channel, no pending command.
REQ-009 Port fifoDataFull  in  NUM_CH  SHALL flag, per channel, no space for response data.
REQ-010 Port writeSDRAM  in  NUM_CH  SHALL give, per channel, the command type (1 = write, 0 = read).
REQ-011 Port fifoReadStrobe  out  NUM_CH  SHALL carry one-cycle command-pop pulses.
REQ-012 Port fifoWriteStrobe  out  NUM_CH  SHALL carry one-cycle response-push pulses.
REQ-013 Port sdramReq  out  1  SHALL carry a one-cycle operation-start pulse.
REQ-014 Port sdramWE  out  1  SHALL select write (1) or read (0) for the current operation.
REQ-015 Port sdramDone  in  1  SHALL carry a one-cycle operation-complete pulse.
REQ-016 Port grantCh  out  $clog2(NUM_CH)  SHALL give the serviced channel index (address/data mux select).
REQ-017 Port arbBusy  out  1  SHALL be 1 whenever the state is not IDLE or WAIT_INIT.
REQ-018 Port simpleArbiterError  out  1  SHALL be a sticky error flag.

Function
REQ-019 States SHALL be WAIT_INIT, IDLE, FIFO_WAIT, ISSUE, SDRAM_WAIT and RESPOND.
REQ-020 WAIT_INIT SHALL move to IDLE on the first cycle sdramReady=1.
REQ-021 A channel SHALL be eligible only when fifoDataEmpty=0 and fifoDataFull=0.
REQ-022 IDLE SHALL grant round-robin, searching from lastGrant+1 modulo NUM_CH; it SHALL pulse fifoReadStrobe[ch], load grantCh and lastGrant, and go to FIFO_WAIT.
REQ-023 In IDLE with no eligible channel, all strobes SHALL stay 0; if sdramReady=0, the state SHALL return to WAIT_INIT.
REQ-024 FIFO_WAIT SHALL last FIFO_LAT cycles; on its last cycle it SHALL register writeSDRAM[grantCh] into sdramWE.
REQ-025 ISSUE SHALL pulse sdramReq for one cycle and go to SDRAM_WAIT; sdramReq SHALL follow fifoReadStrobe by FIFO_LAT+1 cycles.
REQ-026 sdramWE SHALL hold stable from ISSUE until SDRAM_WAIT exits, and SHALL be 0 otherwise.
REQ-027 On sdramDone in SDRAM_WAIT, a read SHALL go to RESPOND and a write SHALL go to IDLE.
REQ-028 sdramDone outside SDRAM_WAIT SHALL be ignored.
REQ-029 RESPOND SHALL pulse fifoWriteStrobe[grantCh] for one cycle and go to IDLE.
REQ-030 sdramReady deasserting mid-operation SHALL NOT abort the operation; it SHALL take effect in IDLE.
REQ-031 An unreachable state encoding SHALL set simpleArbiterError and force WAIT_INIT.
REQ-032 At most one bit of fifoReadStrobe, and at most one bit of fifoWriteStrobe, SHALL be 1 in any cycle.

Reset
REQ-033 Reset SHALL force state WAIT_INIT, lastGrant = NUM_CH-1 (so channel 0 wins first), and all outputs 0, including grantCh and simpleArbiterError.
REQ-034 Reset SHALL take precedence over every other event, including mid-operation, and SHALL emit no strobe in the reset cycle.
REQ-035 simpleArbiterError SHALL clear only on reset.

Configuration
REQ-036 With ARB_SDRAM_TIMEOUT_EN defined, if sdramDone does not arrive within TIMEOUT_CYC cycles in SDRAM_WAIT, the block SHALL set simpleArbiterError, skip RESPOND, and go to IDLE.
REQ-037 Without ARB_SDRAM_TIMEOUT_EN, SDRAM_WAIT SHALL wait indefinitely, and no watchdog counter SHALL exist.

Verification
REQ-038 Reset, sdramReady=0 for 10 cycles, then 1 -> no strobes or sdramReq while 0; IDLE reached 1 cycle after sdramReady rises.
REQ-039 Channel 2 holds a read, FIFO_LAT=1, sdramDone 5 cycles after sdramReq -> fifoReadStrobe=0100 at T, sdramReq at T+2 with sdramWE=0, fifoWriteStrobe=0100 one cycle after sdramDone.
REQ-040 All 4 channels continuously non-empty with writes -> grant order 0,1,2,3,0; no channel served twice before the others.
REQ-041 Channel 1 non-empty but fifoDataFull[1]=1, channel 3 eligible -> channel 3 granted; channel 1 skipped until full clears.
REQ-042 With ARB_SDRAM_TIMEOUT_EN and TIMEOUT_CYC=64, sdramDone withheld -> simpleArbiterError=1 after 64 cycles, return to IDLE, no fifoWriteStrobe; without the macro -> stays in SDRAM_WAIT and error stays 0.
REQ-043 Reset asserted in SDRAM_WAIT, then a late sdramDone -> WAIT_INIT, outputs 0, late sdramDone ignored.
